// File: rtl/coolgirl_cfg_regs_if.sv
// CPU bus view of the multicart config controller: decode inputs plus readback drive.
// Latency: pure wiring; no state lives here.
// Backpressure: none; the CPU bus cannot be stalled.
interface coolgirl_cfg_regs_if;
  logic        romsel;
  logic        cpu_rw_in;
  logic [14:0] cpu_addr_in;
  logic [7:0]  cpu_data_in;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_out_enabled;

  modport master (
    output romsel, cpu_rw_in, cpu_addr_in, cpu_data_in,
    input  cpu_data_out, cpu_data_out_enabled
  );

  modport slave (
    input  romsel, cpu_rw_in, cpu_addr_in, cpu_data_in,
    output cpu_data_out, cpu_data_out_enabled
  );
endinterface

// File: rtl/coolgirl_cfg_regs.sv
// Shadowed, key-protected mapper configuration with atomic commit and optional seal.
// Latency: shadow/FSM update on the edge that samples the write; commit visible 1 cycle after.
// Backpressure: none; one write per m2 edge. Optional macro CFG_READBACK_EN adds shadow readback.
module coolgirl_cfg_regs #(
  parameter logic [7:0] KEY0         = 8'hA5,
  parameter logic [7:0] KEY1         = 8'h5A,
  parameter logic [4:0] RESET_MAPPER = 5'd0
) (
  input  logic                      m2,
  input  logic                      reset,
  coolgirl_cfg_regs_if.slave        cpu,
  output logic [12:0]               cpu_base,
  output logic [6:0]                prg_mask,
  output logic [4:0]                chr_mask,
  output logic [1:0]                sram_page,
  output logic                      sram_enabled,
  output logic                      map_rom_on_6000,
  output logic                      prg_write_enabled,
  output logic                      chr_write_enabled,
  output logic                      four_screen,
  output logic [4:0]                mapper_sel,
  output logic                      cfg_pending,
  output logic                      cfg_open,
  output logic                      cfg_sealed
);

  typedef enum logic [1:0] {
    ST_WAIT_K0 = 2'd0,
    ST_WAIT_K1 = 2'd1,
    ST_OPEN    = 2'd2,
    ST_SEALED  = 2'd3
  } state_t;

  // r4 layout: {four_screen, chr_we, prg_we, map_rom_on_6000, sram_enabled, sram_page[1:0]}
  localparam logic [6:0] FLAGS_RST = 7'b010_0000;

  state_t      r_state;
  logic        r_pending;

  logic [7:0]  r_sh_base_lo;
  logic [4:0]  r_sh_base_hi;
  logic [6:0]  r_sh_prg_mask;
  logic [4:0]  r_sh_chr_mask;
  logic [6:0]  r_sh_flags;
  logic [4:0]  r_sh_mapper;

  logic [12:0] r_base;
  logic [6:0]  r_prg_mask;
  logic [4:0]  r_chr_mask;
  logic [6:0]  r_flags;
  logic [4:0]  r_mapper;

  logic        w_win;
  logic        w_wr;
  logic [2:0]  w_idx;
  logic [7:0]  w_dat;
  logic        w_unused_addr;

  assign w_win         = (cpu.cpu_addr_in[14:12] == 3'b101) & cpu.romsel;
  assign w_wr          = ~cpu.cpu_rw_in & w_win;
  assign w_idx         = cpu.cpu_addr_in[2:0];
  assign w_dat         = cpu.cpu_data_in;
  // Registers alias across the whole $5000-$5FFF window.
  assign w_unused_addr = ^cpu.cpu_addr_in[11:3];

  // Key FSM, shadow writes and atomic commit; reset wins over any same-cycle write.
  always_ff @(posedge m2) begin
    if (reset) begin
      r_state       <= ST_WAIT_K0;
      r_pending     <= 1'b0;
      r_sh_base_lo  <= 8'h00;
      r_sh_base_hi  <= 5'h00;
      r_sh_prg_mask <= 7'h7F;
      r_sh_chr_mask <= 5'h1F;
      r_sh_flags    <= FLAGS_RST;
      r_sh_mapper   <= RESET_MAPPER;
      r_base        <= 13'h0000;
      r_prg_mask    <= 7'h7F;
      r_chr_mask    <= 5'h1F;
      r_flags       <= FLAGS_RST;
      r_mapper      <= RESET_MAPPER;
    end else if (w_wr) begin
      case (r_state)
        ST_WAIT_K0: begin
          if (w_idx == 3'd6 && w_dat == KEY0)
            r_state <= ST_WAIT_K1;
        end
        ST_WAIT_K1: begin
          // A repeated first key byte keeps the sequence alive.
          if (w_idx == 3'd6 && w_dat == KEY1)
            r_state <= ST_OPEN;
          else if (w_idx == 3'd6 && w_dat == KEY0)
            r_state <= ST_WAIT_K1;
          else
            r_state <= ST_WAIT_K0;
        end
        ST_OPEN: begin
          case (w_idx)
            3'd0: begin r_sh_base_lo  <= w_dat;      r_pending <= 1'b1; end
            3'd1: begin r_sh_base_hi  <= w_dat[4:0]; r_pending <= 1'b1; end
            3'd2: begin r_sh_prg_mask <= w_dat[6:0]; r_pending <= 1'b1; end
            3'd3: begin r_sh_chr_mask <= w_dat[4:0]; r_pending <= 1'b1; end
            3'd4: begin r_sh_flags    <= w_dat[6:0]; r_pending <= 1'b1; end
            3'd5: begin r_sh_mapper   <= w_dat[4:0]; r_pending <= 1'b1; end
            3'd6: begin
              // Re-keying relocks but keeps the shadows.
              r_state <= (w_dat == KEY0) ? ST_WAIT_K1 : ST_WAIT_K0;
            end
            default: begin
              // SEAL without COMMIT is deliberately a no-op.
              if (w_dat[0]) begin
                r_base     <= {r_sh_base_hi, r_sh_base_lo};
                r_prg_mask <= r_sh_prg_mask;
                r_chr_mask <= r_sh_chr_mask;
                r_flags    <= r_sh_flags;
                r_mapper   <= r_sh_mapper;
                r_pending  <= 1'b0;
                if (w_dat[7])
                  r_state <= ST_SEALED;
              end
            end
          endcase
        end
        default: begin
          // Sealed: locked until reset.
        end
      endcase
    end
  end

  assign cpu_base          = r_base;
  assign prg_mask          = r_prg_mask;
  assign chr_mask          = r_chr_mask;
  assign sram_page         = r_flags[1:0];
  assign sram_enabled      = r_flags[2];
  assign map_rom_on_6000   = r_flags[3];
  assign prg_write_enabled = r_flags[4];
  assign chr_write_enabled = r_flags[5];
  assign four_screen       = r_flags[6];
  assign mapper_sel        = r_mapper;
  assign cfg_pending       = r_pending;
  assign cfg_open          = (r_state == ST_OPEN);
  assign cfg_sealed        = (r_state == ST_SEALED);

`ifdef CFG_READBACK_EN
  logic       w_rd_en;
  logic [7:0] w_rd_dat;

  assign w_rd_en = cpu.cpu_rw_in & w_win & (r_state == ST_OPEN);

  // Shadow readback mux; key port never reveals anything.
  always_comb begin
    w_rd_dat = 8'h00;
    case (w_idx)
      3'd0:    w_rd_dat = r_sh_base_lo;
      3'd1:    w_rd_dat = {3'b000, r_sh_base_hi};
      3'd2:    w_rd_dat = {1'b0, r_sh_prg_mask};
      3'd3:    w_rd_dat = {3'b000, r_sh_chr_mask};
      3'd4:    w_rd_dat = {1'b0, r_sh_flags};
      3'd5:    w_rd_dat = {3'b000, r_sh_mapper};
      3'd6:    w_rd_dat = 8'h00;
      default: w_rd_dat = {cfg_sealed, 6'b000000, r_pending};
    endcase
  end

  assign cpu.cpu_data_out_enabled = w_rd_en;
  assign cpu.cpu_data_out         = w_rd_en ? w_rd_dat : 8'h00;
`else
  assign cpu.cpu_data_out_enabled = 1'b0;
  assign cpu.cpu_data_out         = 8'h00;
`endif

endmodule
